// File: rtl/io_input_responder.sv
// io_input_responder: waits for a debounced confirm-button press while the CPU
// requests input, then captures the 8 synchronized switches into a 32-bit word
// and returns it with a one-cycle valid pulse.
// Build option: define IO_SIGN_EXT_EN to sign-extend the captured switch value
// (default build zero-extends).
module io_input_responder #(
   parameter int DEBOUNCE_CYCLES = 230000,
   parameter int CNT_W           = 18
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  sw_in,
   input  logic        btn_in,
   input  logic        rd_req,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        waiting
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      WAIT_RELEASE = 2'd2
   } state_t;

   // Two-flop synchronizers for the asynchronous pins
   logic             btn_m_q;
   logic             btn_s_q;
   logic [7:0]       sw_m_q;
   logic [7:0]       sw_s_q;

   // Debounce state
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             btn_db_q;
   logic             btn_db_d;
   logic             btn_db_dly_q;
   logic             rise;

   // Request FSM and registered outputs
   state_t           state_q;
   logic [31:0]      rd_data_q;
   logic             rd_valid_q;
   logic             waiting_q;

   // Widen the captured switch byte to a register-file word
   function automatic logic [31:0] extend(input logic [7:0] v);
`ifdef IO_SIGN_EXT_EN
      return {{24{v[7]}}, v};
`else
      return {24'h0, v};
`endif
   endfunction

   // Bring the raw pins into the clk domain; nothing else touches the pins
   always_ff @(posedge clk) begin
      if (reset) begin
         btn_m_q <= 1'b0;
         btn_s_q <= 1'b0;
         sw_m_q  <= 8'h00;
         sw_s_q  <= 8'h00;
      end else begin
         btn_m_q <= btn_in;
         btn_s_q <= btn_m_q;
         sw_m_q  <= sw_in;
         sw_s_q  <= sw_m_q;
      end
   end

   // Debounced level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
   always_comb begin
      cnt_d    = cnt_q;
      btn_db_d = btn_db_q;
      if (btn_s_q == btn_db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         btn_db_d = btn_s_q;
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Register the debounce counter, debounced level and its one-cycle delay
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q        <= '0;
         btn_db_q     <= 1'b0;
         btn_db_dly_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         btn_db_q     <= btn_db_d;
         btn_db_dly_q <= btn_db_q;
      end
   end

   assign rise = btn_db_q & ~btn_db_dly_q;

   // Request FSM: only a fresh rise seen while waiting produces a capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rd_data_q  <= 32'h0;
         rd_valid_q <= 1'b0;
         waiting_q  <= 1'b0;
      end else begin
         rd_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rd_req) begin
                  state_q   <= WAIT_PRESS;
                  waiting_q <= 1'b1;
               end
            end
            WAIT_PRESS: begin
               // A dropped request wins over a rise in the same cycle
               if (!rd_req) begin
                  state_q   <= IDLE;
                  waiting_q <= 1'b0;
               end else if (rise) begin
                  rd_data_q  <= extend(sw_s_q);
                  rd_valid_q <= 1'b1;
                  waiting_q  <= 1'b0;
                  state_q    <= WAIT_RELEASE;
               end
            end
            WAIT_RELEASE: begin
               // Hold until the button is released and the CPU has let go
               if (!btn_db_q && !rd_req) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q   <= IDLE;
               waiting_q <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign waiting  = waiting_q;

endmodule

// File: tb/tb_io_input_responder.sv
// tb_io_input_responder: directed and randomized stimulus for io_input_responder
// with DEBOUNCE_CYCLES=4, checked against a behavioural model of the request,
// debounce and capture rules.
module tb_io_input_responder;

   localparam int D = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  sw_in;
   logic        btn_in;
   logic        rd_req;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        waiting;

   int n_cmp  = 0;
   int n_bad  = 0;
   int cyc    = 0;
   int vcount = 0;
   int vlast  = -1;

   // Behavioural model state
   bit          m_b1, m_bs;
   bit [7:0]    m_sw1, m_sws;
   bit          m_db, m_dbd;
   bit          hist[$];
   int          phase = 0;   // 0 idle, 1 waiting for press, 2 waiting for release
   logic [31:0] e_data = 32'h0;
   logic        e_valid = 1'b0;
   logic        e_wait = 1'b0;

   io_input_responder #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W          (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .sw_in   (sw_in),
      .btn_in  (btn_in),
      .rd_req  (rd_req),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .waiting (waiting)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ext(input logic [7:0] v);
      int x;
`ifdef IO_SIGN_EXT_EN
      x = int'($signed(v));
`else
      x = int'(v);
`endif
      return 32'(x);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // One clock: advance the model with what the DUT sampled, then compare
   task automatic tick();
      bit ob, odb, odbd, rise, flip;
      bit [7:0] osw;
      @(posedge clk);
      cyc++;
      if (reset) begin
         m_b1 = 0; m_bs = 0; m_sw1 = 8'h0; m_sws = 8'h0;
         m_db = 0; m_dbd = 0; hist.delete();
         phase = 0; e_data = 32'h0; e_valid = 1'b0;
      end else begin
         ob   = m_bs;
         odb  = m_db;
         odbd = m_dbd;
         osw  = m_sws;
         rise = odb & !odbd;
         // debounced level flips once the last D synchronized samples all disagree with it
         hist.push_back(ob);
         if (hist.size() > D) hist.delete(0);
         flip = (hist.size() == D);
         foreach (hist[i]) if (hist[i] == odb) flip = 0;
         m_dbd = odb;
         if (flip) m_db = !odb;
         m_bs  = m_b1;  m_b1  = btn_in;
         m_sws = m_sw1; m_sw1 = sw_in;
         e_valid = 1'b0;
         if (phase == 0) begin
            if (rd_req) phase = 1;
         end else if (phase == 1) begin
            if (!rd_req) phase = 0;
            else if (rise) begin
               e_data  = ext(osw);
               e_valid = 1'b1;
               phase   = 2;
            end
         end else begin
            if (!odb && !rd_req) phase = 0;
         end
      end
      e_wait = (phase == 1);
      #1;
      chk("rd_data",  rd_data, e_data);
      chk("rd_valid", 32'(rd_valid), 32'(e_valid));
      chk("waiting",  32'(waiting), 32'(e_wait));
      if (rd_valid === 1'b1) begin
         vcount++;
         vlast = cyc;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      int t;
      int v0;

      // Reset with the button pressed and all switches on
      reset = 1'b1; btn_in = 1'b1; sw_in = 8'hFF; rd_req = 1'b0;
      ticks(3);
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_data",  rd_data, 32'h0);
         chk("rst_valid", 32'(rd_valid), 32'h0);
         chk("rst_wait",  32'(waiting), 32'h0);
      end
      btn_in = 1'b0;
      ticks(10);

      // Clean press while requesting
      sw_in = 8'hA5; rd_req = 1'b1;
      ticks(2);
      chk("wait_before_press", 32'(waiting), 32'h1);
      v0 = vcount; t = cyc + 1; btn_in = 1'b1;
      ticks(10);
      chk("clean_count", 32'(vcount - v0), 32'd1);
      chk("clean_cycle", 32'(vlast), 32'(t + 6));
      chk("clean_data",  rd_data, ext(8'hA5));
      rd_req = 1'b0; btn_in = 1'b0;
      ticks(10);

      // Bouncing button, then held
      sw_in = 8'h5A; rd_req = 1'b1;
      ticks(2);
      v0 = vcount;
      for (int i = 0; i < 12; i++) begin
         btn_in = ((i % 4) < 2);
         tick();
      end
      t = cyc + 1; btn_in = 1'b1;
      ticks(10);
      chk("bounce_count", 32'(vcount - v0), 32'd1);
      chk("bounce_cycle", 32'(vlast), 32'(t + 6));

      // Button already held before the request
      rd_req = 1'b0; btn_in = 1'b0;
      ticks(10);
      btn_in = 1'b1; sw_in = 8'h7E;
      ticks(10);
      v0 = vcount; rd_req = 1'b1;
      ticks(10);
      chk("held_count", 32'(vcount - v0), 32'd0);
      chk("held_wait",  32'(waiting), 32'h1);
      btn_in = 1'b0;
      ticks(6);
      btn_in = 1'b1;
      ticks(10);
      chk("repress_count", 32'(vcount - v0), 32'd1);
      chk("repress_data",  rd_data, ext(8'h7E));
      rd_req = 1'b0; btn_in = 1'b0;
      ticks(10);

      // Abort while waiting
      rd_req = 1'b1;
      ticks(3);
      chk("abort_wait_hi", 32'(waiting), 32'h1);
      v0 = vcount; rd_req = 1'b0;
      tick();
      chk("abort_wait_lo", 32'(waiting), 32'h0);
      ticks(3);
      chk("abort_count", 32'(vcount - v0), 32'd0);
      chk("abort_data",  rd_data, ext(8'h7E));

      // Reset while waiting for release
      rd_req = 1'b1;
      ticks(2);
      btn_in = 1'b1;
      ticks(10);
      chk("rel_capture", rd_data, ext(8'h7E));
      reset = 1'b1;
      tick();
      chk("midrst_data", rd_data, 32'h0);
      chk("midrst_wait", 32'(waiting), 32'h0);
      reset = 1'b0; rd_req = 1'b0; btn_in = 1'b0;
      ticks(10);

      // Switch changes without a press are ignored
      sw_in = 8'h3C; rd_req = 1'b1;
      ticks(2);
      btn_in = 1'b1;
      ticks(10);
      rd_req = 1'b0; btn_in = 1'b0;
      ticks(10);
      chk("cap_3c", rd_data, ext(8'h3C));
      sw_in = 8'h81;
      ticks(6);
      chk("hold_3c", rd_data, ext(8'h3C));
      rd_req = 1'b1;
      ticks(2);
      btn_in = 1'b1;
      ticks(10);
      chk("cap_81", rd_data, ext(8'h81));
      rd_req = 1'b0; btn_in = 1'b0;
      ticks(10);

      // Randomized traffic against the model
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(9) == 0) rd_req = !rd_req;
         if ($urandom_range(5) == 0) btn_in = !btn_in;
         sw_in = 8'($urandom);
         reset = ($urandom_range(299) == 0);
         tick();
      end
      reset = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
